// File: rtl/song_rom_arbiter_pkg.sv
// song_rom_arbiter_pkg: song ROM constants and arbiter types shared by the arbiter files
package song_rom_arbiter_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int SONG_LEN = 250;
  localparam int ROM_DEPTH = 4 * SONG_LEN;
  localparam logic [7:0] SONG_FINISH = 8'h7C;
  typedef enum logic {REQ_NOTES = 1'b0, REQ_DISPLAY = 1'b1} req_id_e;
  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    oor;
  } tag_t;
endpackage

// File: rtl/song_rom_arbiter_if.sv
// song_rom_arbiter_if: two requester/response channels plus the ROM port
interface song_rom_arbiter_if #(
  parameter int ADDR_W = song_rom_arbiter_pkg::ADDR_W,
  parameter int DATA_W = song_rom_arbiter_pkg::DATA_W
);
  logic              req0_valid, req0_ready, rsp0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] rsp0_data;
  logic              req1_valid, req1_ready, rsp1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] rsp1_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              busy;
  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr, rom_dout,
    input  req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data, rom_addr, busy
  );
  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr, rom_dout,
    output req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data, rom_addr, busy
  );
endinterface

// File: rtl/song_rom_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a registered last-grant pointer
module rr_arbiter2
  import song_rom_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output req_id_e    gnt_id_o
);
  req_id_e last_q, last_d;
  always_comb begin
    gnt_id_o = (req_i == 2'b11) ? (last_q == REQ_NOTES ? REQ_DISPLAY : REQ_NOTES)
                                : (req_i[1] ? REQ_DISPLAY : REQ_NOTES);
    gnt_o = (|req_i) ? (gnt_id_o == REQ_DISPLAY ? 2'b10 : 2'b01) : 2'b00;
    last_d = (|req_i) ? gnt_id_o : last_q;
  end
  // Reset to DISPLAY so NOTES wins the first contention
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= REQ_DISPLAY;
    else last_q <= last_d;
endmodule

// File: rtl/song_rom_arbiter.sv
// song_rom_arbiter: shares one song ROM port between the note streamer and the
// display lookahead, returning tagged responses in fixed-latency order
module song_rom_arbiter #(
  parameter int ADDR_W = song_rom_arbiter_pkg::ADDR_W,
  parameter int DATA_W = song_rom_arbiter_pkg::DATA_W,
  parameter int ROM_DEPTH = song_rom_arbiter_pkg::ROM_DEPTH,
  parameter int ROM_LATENCY = 2,
  parameter logic [DATA_W-1:0] OOR_DATA = DATA_W'(song_rom_arbiter_pkg::SONG_FINISH)
) (
  input logic clk_in,
  input logic rst_in,
  song_rom_arbiter_if.slave bus
);
  import song_rom_arbiter_pkg::*;
  logic [1:0] req_v, gnt;
  req_id_e gnt_id;
  logic [ADDR_W-1:0] addr_g, rom_addr_q;
  tag_t tag_d;
  tag_t [ROM_LATENCY-1:0] tag_q;
  logic rsp_v_q;
  req_id_e rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic v0, v1;
  rr_arbiter2 u_arb (
    .clk(clk_in),
    .rst(rst_in),
    .req_i(req_v),
    .gnt_o(gnt),
    .gnt_id_o(gnt_id)
  );
  always_comb begin
    req_v = {bus.req1_valid, bus.req0_valid} & {2{~rst_in}};
    bus.req0_ready = gnt[0];
    bus.req1_ready = gnt[1];
    addr_g = (gnt_id == REQ_DISPLAY) ? bus.req1_addr : bus.req0_addr;
    bus.rom_addr = (|gnt) ? addr_g : rom_addr_q;
    tag_d.valid = |gnt;
    tag_d.id = gnt_id;
    tag_d.oor = 32'(addr_g) >= ROM_DEPTH;
    bus.busy = 1'b0;
    for (int i = 0; i < ROM_LATENCY; i++) bus.busy = bus.busy | tag_q[i].valid;
    v0 = rsp_v_q && rsp_id_q == REQ_NOTES;
    v1 = rsp_v_q && rsp_id_q == REQ_DISPLAY;
    bus.rsp0_valid = v0;
    bus.rsp1_valid = v1;
    bus.rsp0_data = v0 ? rsp_data_q : '0;
    bus.rsp1_data = v1 ? rsp_data_q : '0;
  end
  // Tag leaves the last stage together with its ROM word; response is registered
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      rom_addr_q <= '0;
      tag_q <= '0;
      rsp_v_q <= 1'b0;
      rsp_id_q <= REQ_NOTES;
      rsp_data_q <= '0;
    end else begin
      rom_addr_q <= bus.rom_addr;
      tag_q[0] <= tag_d;
      for (int i = 1; i < ROM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      rsp_v_q <= tag_q[ROM_LATENCY-1].valid;
      rsp_id_q <= tag_q[ROM_LATENCY-1].id;
      rsp_data_q <= tag_q[ROM_LATENCY-1].oor ? OOR_DATA : bus.rom_dout;
    end
endmodule

// File: tb/tb_song_rom_arbiter.sv
// tb_song_rom_arbiter: latency-2 and latency-1 builds side by side against a queue model
module tb_song_rom_arbiter;
  typedef struct {
    int d;
    int due;
    logic id;
    logic [7:0] data;
  } pend_t;
  logic clk = 1'b0, rst = 1'b1, v0 = 1'b0, v1 = 1'b0;
  logic [9:0] a0 = '0, a1 = '0;
  int cyc = 0, checks = 0, errors = 0;
  logic last = 1'b1, p0 = 1'b0, p1 = 1'b0;
  logic [9:0] ra_m = '0, pa0 = '0, pa1 = '0;
  pend_t pq[$];
  logic [9:0] pipe2 [2] = '{default: '0};
  logic [9:0] pipe1 = '0;
  logic [1:0] o_r0, o_r1, o_v0, o_v1, o_busy;
  logic [7:0] o_d0 [2];
  logic [7:0] o_d1 [2];
  logic [9:0] o_ra [2];
  song_rom_arbiter_if bus2 ();
  song_rom_arbiter_if bus1 ();
  song_rom_arbiter #(.ROM_LATENCY(2)) dut2 (.clk_in(clk), .rst_in(rst), .bus(bus2));
  song_rom_arbiter #(.ROM_LATENCY(1)) dut1 (.clk_in(clk), .rst_in(rst), .bus(bus1));
  always #5 clk = ~clk;
  assign bus2.req0_valid = v0;
  assign bus2.req0_addr = a0;
  assign bus2.req1_valid = v1;
  assign bus2.req1_addr = a1;
  assign bus1.req0_valid = v0;
  assign bus1.req0_addr = a0;
  assign bus1.req1_valid = v1;
  assign bus1.req1_addr = a1;
  // ROM content is addr+1; each build gets a ROM of its own latency
  always @(posedge clk) begin
    pipe2[0] <= bus2.rom_addr;
    pipe2[1] <= pipe2[0];
    pipe1 <= bus1.rom_addr;
  end
  assign bus2.rom_dout = 8'(pipe2[1] + 10'd1);
  assign bus1.rom_dout = 8'(pipe1 + 10'd1);
  assign o_r0 = {bus1.req0_ready, bus2.req0_ready};
  assign o_r1 = {bus1.req1_ready, bus2.req1_ready};
  assign o_v0 = {bus1.rsp0_valid, bus2.rsp0_valid};
  assign o_v1 = {bus1.rsp1_valid, bus2.rsp1_valid};
  assign o_busy = {bus1.busy, bus2.busy};
  assign o_d0[0] = bus2.rsp0_data;
  assign o_d0[1] = bus1.rsp0_data;
  assign o_d1[0] = bus2.rsp1_data;
  assign o_d1[1] = bus1.rsp1_data;
  assign o_ra[0] = bus2.rom_addr;
  assign o_ra[1] = bus1.rom_addr;

  function automatic logic [7:0] rom_f(input logic [9:0] a);
    return (a >= 10'd1000) ? 8'h7C : 8'(a + 10'd1);
  endfunction
  function automatic logic [1:0] gnt_f(input logic x0, input logic x1, input logic lst);
    return (x0 && x1) ? (lst ? 2'b01 : 2'b10) : {x1, x0};
  endfunction
  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut_lat%0d t=%0t actual=%h required=%h", nm, (d == 0) ? 2 : 1, $time, act, exp);
    end
  endtask

  // Model: decides accepts from the arbitration rules and schedules responses
  always @(posedge clk) begin
    logic [1:0] g;
    pend_t p;
    if (rst) begin
      pq.delete();
      last = 1'b1;
      ra_m = '0;
      p0 = 1'b0;
      p1 = 1'b0;
    end else begin
      if (p0) chk("hold0", 0, 32'({v0, a0}), 32'({1'b1, pa0}));
      if (p1) chk("hold1", 0, 32'({v1, a1}), 32'({1'b1, pa1}));
      g = gnt_f(v0, v1, last);
      if (|g) begin
        ra_m = g[1] ? a1 : a0;
        last = g[1];
        for (int d = 0; d < 2; d++) begin
          p.d = d;
          p.due = cyc + 1 + ((d == 0) ? 2 : 1);
          p.id = g[1];
          p.data = rom_f(ra_m);
          pq.push_back(p);
        end
      end
      p0 = v0 && !g[0];
      pa0 = a0;
      p1 = v1 && !g[1];
      pa1 = a1;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [1:0] eg;
    logic [9:0] era;
    logic ev0, ev1, eb;
    logic [7:0] ed;
    eg = rst ? 2'b00 : gnt_f(v0, v1, last);
    era = rst ? 10'd0 : (eg[1] ? a1 : (eg[0] ? a0 : ra_m));
    for (int d = 0; d < 2; d++) begin
      ev0 = 1'b0;
      ev1 = 1'b0;
      eb = 1'b0;
      ed = '0;
      if (!rst)
        foreach (pq[i])
          if (pq[i].d == d) begin
            if (pq[i].due == cyc) begin
              ev0 = !pq[i].id;
              ev1 = pq[i].id;
              ed = pq[i].data;
            end
            if (pq[i].due > cyc) eb = 1'b1;
          end
      chk("ready", d, 32'({o_r1[d], o_r0[d]}), 32'(eg));
      chk("rom_addr", d, 32'(o_ra[d]), 32'(era));
      chk("rsp0", d, 32'({o_v0[d], o_d0[d]}), 32'({ev0, ev0 ? ed : 8'h00}));
      chk("rsp1", d, 32'({o_v1[d], o_d1[d]}), 32'({ev1, ev1 ? ed : 8'h00}));
      chk("busy", d, 32'(o_busy[d]), 32'(eb));
    end
  end

  task automatic step(input logic nv0, input logic [9:0] na0, input logic nv1, input logic [9:0] na1, input int eg);
    v0 = nv0;
    a0 = na0;
    v1 = nv1;
    a1 = na1;
    #1;
    if (eg >= 0) chk("grant_lit", 0, 32'({o_r1[0], o_r0[0]}), 32'(eg));
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 1'b0, 10'd0, -1);
  endtask
  task automatic reset_pulse();
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    v0 = 1'b1;
    a0 = 10'd5;
    #1;
    chk("rst_ready_lit", 0, 32'(o_r0[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // V1: lone request, data addr+1
    step(1'b1, 10'd5, 1'b0, 10'd0, 2'b01);
    idle(1);
    chk("v1_lat1_lit", 1, 32'({o_v0[1], o_d0[1]}), 32'({1'b1, 8'h06}));
    idle(1);
    chk("v1_lat2_lit", 0, 32'({o_v0[0], o_d0[0], o_v1[0]}), 32'({1'b1, 8'h06, 1'b0}));
    idle(2);
    // V2/V6: contention alternates starting with requester 0
    reset_pulse();
    step(1'b1, 10'd10, 1'b1, 10'd20, 2'b01);
    step(1'b1, 10'd11, 1'b1, 10'd20, 2'b10);
    step(1'b1, 10'd11, 1'b1, 10'd21, 2'b01);
    chk("v2_lat2_lit", 0, 32'({o_v0[0], o_d0[0]}), 32'({1'b1, 8'h0B}));
    chk("v6_lat1_lit", 1, 32'({o_v1[1], o_d1[1]}), 32'({1'b1, 8'h15}));
    step(1'b1, 10'd12, 1'b1, 10'd21, 2'b10);
    step(1'b1, 10'd12, 1'b0, 10'd0, 2'b01);
    idle(3);
    // V3: out-of-range and edge addresses
    step(1'b0, 10'd0, 1'b1, 10'd1000, 2'b10);
    idle(2);
    chk("v3_oor_lit", 0, 32'({o_v1[0], o_d1[0]}), 32'({1'b1, 8'h7C}));
    step(1'b1, 10'd999, 1'b0, 10'd0, 2'b01);
    step(1'b0, 10'd0, 1'b1, 10'd1023, 2'b10);
    idle(3);
    // V4: back-to-back song-boundary reads
    for (int a = 250; a < 255; a++) begin
      step(1'b1, 10'(a), 1'b0, 10'd0, 2'b01);
      if (a == 252) chk("v4_busy_lit", 0, 32'(o_busy[0]), 32'd1);
    end
    idle(4);
    // V5: reset one cycle after an accept drops the read
    step(1'b1, 10'd40, 1'b0, 10'd0, 2'b01);
    rst = 1'b1;
    v0 = 1'b0;
    #1;
    chk("v5_zero_lit", 0, 32'({o_v0[0], o_busy[0], o_ra[0]}), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    step(1'b1, 10'd50, 1'b1, 10'd60, 2'b01);
    step(1'b0, 10'd0, 1'b1, 10'd60, 2'b10);
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
